// File: rtl/alu_op_pkg.sv
// Shared opcode constants and FSM encoding for the execution stage and ALU control.
package alu_op_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_JR  = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1110;
  localparam logic [3:0] OP_NOP = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Shift ops go through the iterative shifter; everything else is single-cycle.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// Combinational evaluator for the single-cycle operations.
module alu_logic_unit
  import alu_op_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  // Unknown codes (and shift codes, handled elsewhere) yield zero.
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOR:  result = ~(a | b);
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_JR:   result = a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_alu.sv
// Execution stage: single-cycle logic/arith ops plus a one-bit-per-cycle shifter,
// with a start/busy/done handshake for the datapath control FSM.
//
// Handshake: start is sampled only in IDLE; the op's operands are captured on
// that edge. busy is high from the next cycle through the DONE cycle, and done
// pulses for exactly one cycle when ALUResult/Zero carry the new result. start
// seen in SHIFT or DONE is dropped, never queued.
module multi_cycle_alu
  import alu_op_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             ALUOperation,
  input  logic [DATA_WIDTH-1:0]  A,
  input  logic [DATA_WIDTH-1:0]  B,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  ALUResult,
  output logic                   Zero,
  output state_t                 fsm_state
);

  state_t                 state;
  logic [DATA_WIDTH-1:0]  shreg;
  logic [SHAMT_WIDTH-1:0] count;
  logic                   dir_right;
  logic [DATA_WIDTH-1:0]  logic_result;
  logic [DATA_WIDTH-1:0]  shift_next;

  alu_logic_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_logic (
    .op    (ALUOperation),
    .a     (A),
    .b     (B),
    .result(logic_result)
  );

  // One-bit step of the shifter, zero fill in both directions.
  always_comb begin
    shift_next = dir_right ? (shreg >> 1) : (shreg << 1);
  end

  assign fsm_state = state;

  // Control FSM, shift register/counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      ALUResult <= '0;
      Zero      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      shreg     <= '0;
      dir_right <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (is_shift_op(ALUOperation)) begin
              shreg     <= B;
              count     <= shamt;
              dir_right <= (ALUOperation == OP_SRL);
              if (shamt == '0) begin
                ALUResult <= B;
                Zero      <= (B == '0);
                done      <= 1'b1;
                state     <= S_DONE;
              end else begin
                state <= S_SHIFT;
              end
            end else begin
              ALUResult <= logic_result;
              Zero      <= (logic_result == '0);
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          shreg <= shift_next;
          count <= count - SHAMT_WIDTH'(1);
          if (count == SHAMT_WIDTH'(1)) begin
            ALUResult <= shift_next;
            Zero      <= (shift_next == '0);
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_alu.sv
// Directed testbench for multi_cycle_alu.
module tb_multi_cycle_alu;
  import alu_op_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  ALUOperation;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] ALUResult;
  logic        Zero;
  state_t      fsm_state;

  int checks   = 0;
  int failures = 0;

  multi_cycle_alu #(
    .DATA_WIDTH (32),
    .SHAMT_WIDTH(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ALUOperation(ALUOperation),
    .A           (A),
    .B           (B),
    .shamt       (shamt),
    .busy        (busy),
    .done        (done),
    .ALUResult   (ALUResult),
    .Zero        (Zero),
    .fsm_state   (fsm_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: start at a posedge (edge 0), scramble inputs afterwards, then
  // count cycles until done. lat = -1 on timeout. Returns at the done cycle's negedge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, output int lat, output int busy_cycles);
    @(negedge clk);
    ALUOperation = op;
    A = a;
    B = b;
    shamt = sh;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = ~a;
    B = ~b;
    shamt = ~sh;
    ALUOperation = OP_NOP;
    lat = -1;
    busy_cycles = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    ALUOperation = OP_NOP;
    A = '0;
    B = '0;
    shamt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ALUResult !== 32'h0 || Zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || fsm_state !== S_IDLE) begin
      failures++;
      $display("FAIL reset: result=%h zero=%b busy=%b done=%b state=%0d, want 0/1/0/0/IDLE",
               ALUResult, Zero, busy, done, fsm_state);
    end
    reset = 1'b1;
  endtask

  task automatic test_single_cycle();
    logic [3:0]  ops [9];
    logic [31:0] as  [9];
    logic [31:0] bs  [9];
    logic [31:0] exp [9];
    int lat, bc;
    ops[0] = OP_ADD; as[0] = 32'h7FFFFFFF; bs[0] = 32'h00000001; exp[0] = 32'h80000000;
    ops[1] = OP_SUB; as[1] = 32'h12345678; bs[1] = 32'h12345678; exp[1] = 32'h00000000;
    ops[2] = OP_NOR; as[2] = 32'hFFFFFFFF; bs[2] = 32'hFFFFFFFF; exp[2] = 32'h00000000;
    ops[3] = OP_AND; as[3] = 32'hF0F0F0F0; bs[3] = 32'hFF00FF00; exp[3] = 32'hF000F000;
    ops[4] = OP_OR;  as[4] = 32'hF0F0F0F0; bs[4] = 32'hFF00FF00; exp[4] = 32'hFFF0FFF0;
    ops[5] = OP_JR;  as[5] = 32'hDEADBEEF; bs[5] = 32'h11111111; exp[5] = 32'hDEADBEEF;
    ops[6] = OP_SUB; as[6] = 32'h00000000; bs[6] = 32'h00000001; exp[6] = 32'hFFFFFFFF;
    ops[7] = OP_NOP; as[7] = 32'h12345678; bs[7] = 32'h9ABCDEF0; exp[7] = 32'h00000000;
    ops[8] = OP_NOR; as[8] = 32'h0F0F0000; bs[8] = 32'h00000F0F; exp[8] = 32'hF0F0F0F0;
    for (int i = 0; i < 9; i++) begin
      run_op(ops[i], as[i], bs[i], 5'd7, lat, bc);
      checks++;
      if (lat !== 1 || ALUResult !== exp[i] || Zero !== (exp[i] == 32'h0) || busy !== 1'b1) begin
        failures++;
        $display("FAIL single_cycle[%0d] op=%b: lat=%0d result=%h zero=%b busy=%b, want lat=1 result=%h zero=%b busy=1",
                 i, ops[i], lat, ALUResult, Zero, busy, exp[i], (exp[i] == 32'h0));
      end
    end
  endtask

  task automatic test_unknown_op();
    int lat, bc;
    run_op(4'b0111, 32'hAAAA5555, 32'h5555AAAA, 5'd3, lat, bc);
    checks++;
    if (lat !== 1 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL unknown_op: lat=%0d result=%h zero=%b, want lat=1 result=0 zero=1", lat, ALUResult, Zero);
    end
  endtask

  task automatic test_shift();
    int lat, bc;
    run_op(OP_SLL, 32'h0, 32'h00000003, 5'd4, lat, bc);
    checks++;
    if (lat !== 5 || bc !== 5 || ALUResult !== 32'h30 || Zero !== 1'b0) begin
      failures++;
      $display("FAIL sll4: lat=%0d busy_cycles=%0d result=%h zero=%b, want 5/5/00000030/0", lat, bc, ALUResult, Zero);
    end
    run_op(OP_SRL, 32'h0, 32'h80000000, 5'd31, lat, bc);
    checks++;
    if (lat !== 32 || ALUResult !== 32'h1 || Zero !== 1'b0) begin
      failures++;
      $display("FAIL srl31: lat=%0d result=%h zero=%b, want 32/00000001/0", lat, ALUResult, Zero);
    end
    run_op(OP_SRL, 32'h0, 32'hA5A5A5A5, 5'd0, lat, bc);
    checks++;
    if (lat !== 1 || ALUResult !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL srl0: lat=%0d result=%h, want 1/a5a5a5a5", lat, ALUResult);
    end
    run_op(OP_SLL, 32'h0, 32'h80000001, 5'd1, lat, bc);
    checks++;
    if (lat !== 2 || ALUResult !== 32'h00000002) begin
      failures++;
      $display("FAIL sll1: lat=%0d result=%h, want 2/00000002", lat, ALUResult);
    end
    run_op(OP_SLL, 32'h0, 32'h00000100, 5'd24, lat, bc);
    checks++;
    if (lat !== 25 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL sll24_zero: lat=%0d result=%h zero=%b, want 25/00000000/1", lat, ALUResult, Zero);
    end
  endtask

  task automatic test_start_during_shift();
    int lat;
    int extra_done;
    @(negedge clk);
    ALUOperation = OP_SRL;
    B = 32'hF0000000;
    A = 32'h0;
    shamt = 5'd8;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 3) begin
        ALUOperation = OP_ADD;
        A = 32'h1;
        B = 32'h1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat !== 9 || ALUResult !== 32'h00F00000) begin
      failures++;
      $display("FAIL start_in_shift: lat=%0d result=%h, want 9/00f00000", lat, ALUResult);
    end
    // start asserted in the DONE cycle must be dropped
    ALUOperation = OP_ADD;
    A = 32'h2;
    B = 32'h3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    extra_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) extra_done++;
    end
    checks++;
    if (extra_done !== 0 || ALUResult !== 32'h00F00000) begin
      failures++;
      $display("FAIL start_in_done: activity_cycles=%0d result=%h, want 0/00f00000", extra_done, ALUResult);
    end
  endtask

  task automatic test_hold();
    int lat, bc;
    run_op(OP_OR, 32'h00000050, 32'h00000005, 5'd0, lat, bc);
    repeat (3) @(negedge clk);
    checks++;
    if (ALUResult !== 32'h55 || Zero !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold: result=%h zero=%b done=%b busy=%b, want 00000055/0/0/0", ALUResult, Zero, done, busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, bc;
    logic [31:0] r1;
    run_op(OP_ADD, 32'h00000010, 32'h00000020, 5'd0, lat1, bc);
    r1 = ALUResult;
    run_op(OP_SUB, 32'h00000100, 32'h00000001, 5'd0, lat2, bc);
    checks++;
    if (lat1 !== 1 || lat2 !== 1 || r1 !== 32'h30 || ALUResult !== 32'hFF) begin
      failures++;
      $display("FAIL back_to_back: lat=%0d,%0d results=%h,%h, want 1,1 00000030,000000ff", lat1, lat2, r1, ALUResult);
    end
  endtask

  task automatic test_reset_mid_shift();
    int seen_done;
    @(negedge clk);
    ALUOperation = OP_SLL;
    A = 32'h0;
    B = 32'h00000001;
    shamt = 5'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (fsm_state !== S_IDLE || busy !== 1'b0 || done !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_shift: state=%0d busy=%b done=%b result=%h zero=%b, want IDLE/0/0/0/1",
               fsm_state, busy, done, ALUResult, Zero);
    end
    seen_done = 0;
    repeat (14) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    checks++;
    if (seen_done !== 0 || ALUResult !== 32'h0) begin
      failures++;
      $display("FAIL reset_no_done: activity_cycles=%0d result=%h, want 0/00000000", seen_done, ALUResult);
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_unknown_op();
    test_shift();
    test_start_during_shift();
    test_hold();
    test_back_to_back();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
